// File: rtl/sram_write_packer.sv
// Packs pairs of DATA_WIDTH elements into SRAM words and writes them at incrementing addresses.
// Define SRAM_WR_HALF_SWAP_EN to put even elements in the high half and odd elements in the low half.
module sram_write_packer #(
  parameter int MAX_ADDR_WIDTH = 16,
  parameter int SRAM_WIDTH_O   = 64,
  parameter int DATA_WIDTH     = 32,
  parameter int LEN_WIDTH      = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [MAX_ADDR_WIDTH-1:0] base_addr_i,
  input  logic [LEN_WIDTH-1:0]      len_i,
  input  logic                      s_valid_i,
  input  logic [DATA_WIDTH-1:0]     s_data_i,
  output logic                      s_ready_o,
  output logic                      sram_en_o,
  output logic                      sram_we_o,
  output logic [MAX_ADDR_WIDTH-1:0] sram_addr_o,
  output logic [SRAM_WIDTH_O-1:0]   sram_data_o,
  output logic                      busy_o,
  output logic                      done_o
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [MAX_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]      len_q, len_d;
  logic [LEN_WIDTH-1:0]      cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]      cnt_inc;
  logic [DATA_WIDTH-1:0]     lo_q, lo_d;
  logic [SRAM_WIDTH_O-1:0]   data_q, data_d;
  logic                      en_q, en_d;
  logic [SRAM_WIDTH_O-1:0]   pair_w;
  logic [SRAM_WIDTH_O-1:0]   tail_w;
  logic [DATA_WIDTH-1:0]     zero_w;
  logic                      accept;
  logic                      last;

  assign zero_w = {DATA_WIDTH{1'b0}};

`ifdef SRAM_WR_HALF_SWAP_EN
  assign pair_w = {lo_q, s_data_i};
  assign tail_w = {s_data_i, zero_w};
`else
  assign pair_w = {s_data_i, lo_q};
  assign tail_w = {zero_w, s_data_i};
`endif

  assign s_ready_o   = (state_q == RUN) && (cnt_q < len_q);
  assign accept      = s_valid_i && s_ready_o;
  assign cnt_inc     = cnt_q + 1'b1;
  assign last        = (cnt_inc == len_q);
  assign sram_en_o   = en_q;
  assign sram_we_o   = en_q;
  assign sram_addr_o = addr_q;
  assign sram_data_o = data_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    data_d  = data_q;
    en_d    = 1'b0;
    // address advances once the write it labelled has gone out
    if (en_q) begin
      addr_d = addr_q + 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d  = base_addr_i;
          len_d   = len_i;
          cnt_d   = '0;
          lo_d    = '0;
          state_d = (len_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (!cnt_q[0]) begin
            lo_d = s_data_i;
            if (last) begin
              data_d  = tail_w;
              en_d    = 1'b1;
              state_d = FLUSH;
            end
          end else begin
            data_d = pair_w;
            en_d   = 1'b1;
          end
        end else if (cnt_q == len_q) begin
          state_d = DONE;
        end
      end
      FLUSH: begin
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      lo_q    <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      data_q  <= data_d;
      en_q    <= en_d;
    end
  end

endmodule

// File: tb/tb_sram_write_packer.sv
// Self-checking bench for sram_write_packer; honours SRAM_WR_HALF_SWAP_EN
// when defined for both DUT and reference model.
module tb_sram_write_packer;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int LW = 16;
  localparam int SW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [LW-1:0] len = '0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          sram_en;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [SW-1:0] sram_data;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [AW-1:0] wr_addr_q[$];
  logic [SW-1:0] wr_data_q[$];
  int            wr_cyc_q[$];
  int            done_cyc_q[$];
  int            busy_cnt;
  int            strobe_err;
  int            stream_left;

  logic [DW-1:0] elems[$];
  logic [AW-1:0] exp_addr[$];
  logic [SW-1:0] exp_data[$];

  sram_write_packer #(
    .MAX_ADDR_WIDTH(AW),
    .SRAM_WIDTH_O  (SW),
    .DATA_WIDTH    (DW),
    .LEN_WIDTH     (LW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .base_addr_i(base),
    .len_i      (len),
    .s_valid_i  (s_valid),
    .s_data_i   (s_data),
    .s_ready_o  (s_ready),
    .sram_en_o  (sram_en),
    .sram_we_o  (sram_we),
    .sram_addr_o(sram_addr),
    .sram_data_o(sram_data),
    .busy_o     (busy),
    .done_o     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (sram_en) begin
        wr_addr_q.push_back(sram_addr);
        wr_data_q.push_back(sram_data);
        wr_cyc_q.push_back(cyc);
      end
      if (done) done_cyc_q.push_back(cyc);
      if (busy) busy_cnt++;
      if (sram_we && !sram_en) strobe_err++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time limit reached, got no end, want finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    done_cyc_q.delete();
    busy_cnt = 0;
    strobe_err = 0;
  endtask

  // Reference: word k holds elements 2k and 2k+1 (missing odd tail = 0).
  task automatic build_expected(input logic [AW-1:0] b, input int n);
    logic [DW-1:0] e0, e1;
    exp_addr.delete();
    exp_data.delete();
    for (int k = 0; 2 * k < n; k++) begin
      e0 = elems[2*k];
      e1 = (2 * k + 1 < n) ? elems[2*k+1] : '0;
`ifdef SRAM_WR_HALF_SWAP_EN
      exp_data.push_back({e0, e1});
`else
      exp_data.push_back({e1, e0});
`endif
      exp_addr.push_back(AW'(b + AW'(k)));
    end
  endtask

  task automatic xfer(input logic [AW-1:0] b, input int n,
                      input bit gaps, input bit spam);
    int idx;
    int budget;
    bit fire;
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1;
    base = b;
    len = n[LW-1:0];
    @(posedge clk); #1;
    start = 1'b0;
    base = AW'($urandom);
    len = LW'($urandom);
    idx = 0;
    budget = 0;
    while (idx < n && budget < 500) begin
      s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      s_data = elems[idx];
      if (spam) start = $urandom_range(0, 1) == 1;
      @(negedge clk);
      fire = s_valid && s_ready;
      @(posedge clk); #1;
      if (fire) idx++;
      budget++;
    end
    stream_left = n - idx;
    start = 1'b0;
    s_valid = 1'b1;
    s_data = 32'hDEAD_BEEF;
    budget = 0;
    while (done_cyc_q.size() == 0 && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if ({s_ready, sram_en, sram_we, busy, done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b want 00000",
               {s_ready, sram_en, sram_we, busy, done});
    end
    checks++;
    if (sram_addr !== '0 || sram_data !== '0) begin
      errors++;
      $display("FAIL reset_bus: got addr %h data %h want 0", sram_addr, sram_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [SW-1:0] w0, w1;
`ifdef SRAM_WR_HALF_SWAP_EN
    w0 = 64'h0000000A_0000000B;
    w1 = 64'h0000000C_0000000D;
`else
    w0 = 64'h0000000B_0000000A;
    w1 = 64'h0000000D_0000000C;
`endif
    elems = '{32'hA, 32'hB, 32'hC, 32'hD};
    xfer(16'h0010, 4, 1'b0, 1'b0);
    checks++;
    if (wr_addr_q.size() != 2) begin
      errors++;
      $display("FAIL basic_count: got %0d writes want 2", wr_addr_q.size());
    end else begin
      checks++;
      if (wr_addr_q[0] !== 16'h0010 || wr_data_q[0] !== w0) begin
        errors++;
        $display("FAIL basic_w0: got %h/%h want 0010/%h", wr_addr_q[0], wr_data_q[0], w0);
      end
      checks++;
      if (wr_addr_q[1] !== 16'h0011 || wr_data_q[1] !== w1) begin
        errors++;
        $display("FAIL basic_w1: got %h/%h want 0011/%h", wr_addr_q[1], wr_data_q[1], w1);
      end
      checks++;
      if (wr_cyc_q[1] - wr_cyc_q[0] != 2) begin
        errors++;
        $display("FAIL basic_rate: got spacing %0d want 2", wr_cyc_q[1] - wr_cyc_q[0]);
      end
      checks++;
      if (done_cyc_q.size() != 1 || done_cyc_q[0] != wr_cyc_q[1] + 1) begin
        errors++;
        $display("FAIL basic_done: got %0d pulses want 1 at cycle %0d", done_cyc_q.size(), wr_cyc_q[1] + 1);
      end
    end
    checks++;
    if (strobe_err != 0) begin
      errors++;
      $display("FAIL basic_we_no_en: got %0d want 0", strobe_err);
    end
  endtask

  task automatic test_flush();
    elems.delete();
    for (int i = 0; i < 3; i++) elems.push_back($urandom);
    build_expected(16'h0007, 3);
    xfer(16'h0007, 3, 1'b0, 1'b0);
    checks++;
    if (wr_addr_q.size() != 2) begin
      errors++;
      $display("FAIL flush_count: got %0d want 2", wr_addr_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (wr_addr_q[i] !== exp_addr[i] || wr_data_q[i] !== exp_data[i]) begin
          errors++;
          $display("FAIL flush_w%0d: got %h/%h want %h/%h", i,
                   wr_addr_q[i], wr_data_q[i], exp_addr[i], exp_data[i]);
        end
      end
      checks++;
      if (done_cyc_q.size() != 1 || done_cyc_q[0] != wr_cyc_q[1] + 1) begin
        errors++;
        $display("FAIL flush_done: got %0d pulses want 1 after last write", done_cyc_q.size());
      end
    end
  endtask

  task automatic test_zero_len();
    elems.delete();
    xfer(16'h0123, 0, 1'b0, 1'b0);
    checks++;
    if (wr_addr_q.size() != 0) begin
      errors++;
      $display("FAIL zero_writes: got %0d want 0", wr_addr_q.size());
    end
    checks++;
    if (done_cyc_q.size() != 1) begin
      errors++;
      $display("FAIL zero_done: got %0d pulses want 1", done_cyc_q.size());
    end
    checks++;
    if (busy_cnt != 1) begin
      errors++;
      $display("FAIL zero_busy: got %0d cycles want 1", busy_cnt);
    end
  endtask

  task automatic test_wrap();
    elems.delete();
    for (int i = 0; i < 4; i++) elems.push_back($urandom);
    build_expected(16'hFFFF, 4);
    xfer(16'hFFFF, 4, 1'b0, 1'b0);
    checks++;
    if (wr_addr_q.size() != 2) begin
      errors++;
      $display("FAIL wrap_count: got %0d want 2", wr_addr_q.size());
    end else begin
      checks++;
      if (wr_addr_q[1] !== 16'h0000 || wr_data_q[1] !== exp_data[1]) begin
        errors++;
        $display("FAIL wrap_w1: got %h/%h want 0000/%h", wr_addr_q[1], wr_data_q[1], exp_data[1]);
      end
    end
  endtask

  task automatic test_gaps_start();
    elems.delete();
    for (int i = 0; i < 7; i++) elems.push_back($urandom);
    build_expected(16'h0200, 7);
    xfer(16'h0200, 7, 1'b1, 1'b1);
    checks++;
    if (stream_left != 0 || wr_addr_q.size() != exp_addr.size()) begin
      errors++;
      $display("FAIL gaps_count: got %0d writes (%0d unsent) want %0d",
               wr_addr_q.size(), stream_left, exp_addr.size());
    end else begin
      for (int i = 0; i < exp_addr.size(); i++) begin
        checks++;
        if (wr_addr_q[i] !== exp_addr[i] || wr_data_q[i] !== exp_data[i]) begin
          errors++;
          $display("FAIL gaps_w%0d: got %h/%h want %h/%h", i,
                   wr_addr_q[i], wr_data_q[i], exp_addr[i], exp_data[i]);
        end
      end
    end
    checks++;
    if (done_cyc_q.size() != 1) begin
      errors++;
      $display("FAIL gaps_done: got %0d pulses want 1", done_cyc_q.size());
    end
  endtask

  task automatic test_random();
    int n;
    int bad;
    logic [AW-1:0] b;
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(1, 11);
      b = AW'($urandom);
      elems.delete();
      for (int i = 0; i < n; i++) elems.push_back($urandom);
      build_expected(b, n);
      xfer(b, n, $urandom_range(0, 1) == 1, 1'b0);
      bad = 0;
      if (wr_addr_q.size() != exp_addr.size()) bad = 1;
      else
        for (int i = 0; i < exp_addr.size(); i++)
          if (wr_addr_q[i] !== exp_addr[i] || wr_data_q[i] !== exp_data[i]) bad = 1;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL rand_xfer%0d: got %0d writes want %0d (len %0d base %h)",
                 t, wr_addr_q.size(), exp_addr.size(), n, b);
      end
      checks++;
      if (done_cyc_q.size() != 1 || wr_cyc_q.size() == 0 ||
          done_cyc_q[0] != wr_cyc_q[wr_cyc_q.size()-1] + 1) begin
        errors++;
        $display("FAIL rand_done%0d: got %0d pulses want 1 right after last write", t, done_cyc_q.size());
      end
    end
  endtask

  task automatic test_mid_reset();
    int budget;
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1;
    base = 16'h0400;
    len = 16'd8;
    @(posedge clk); #1;
    start = 1'b0;
    budget = 0;
    while (wr_addr_q.size() == 0 && budget < 100) begin
      s_valid = $urandom_range(0, 1) == 1;
      s_data = $urandom;
      @(posedge clk); #1;
      budget++;
    end
    checks++;
    if (wr_addr_q.size() == 0) begin
      errors++;
      $display("FAIL mreset_first_write: got 0 writes want >=1");
    end
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({s_ready, sram_en, sram_we, busy, done} !== 5'b0 ||
        sram_addr !== '0 || sram_data !== '0) begin
      errors++;
      $display("FAIL mreset_outputs: got %b addr %h data %h want all 0",
               {s_ready, sram_en, sram_we, busy, done}, sram_addr, sram_data);
    end
    clear_mon();
    s_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    s_valid = 1'b0;
    checks++;
    if (wr_addr_q.size() != 0 || done_cyc_q.size() != 0) begin
      errors++;
      $display("FAIL mreset_abort: got %0d writes %0d done want 0 0",
               wr_addr_q.size(), done_cyc_q.size());
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_flush();
    test_zero_len();
    test_wrap();
    test_gaps_start();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
